// File: rtl/lcd_bus_responder.sv
// ---------------------------------------------------------------------------
// lcd_bus_responder
//
// HD44780-compatible bus responder. It is the display end of the
// lcd_rs/lcd_rw/lcd_en/lcd_data bus. It decodes 8-bit-mode commands and data
// writes into a 2x16 DDRAM character buffer and holds the display-control
// state. It can serve as an on-chip mirror/checker of the LCD interface.
//
// Optional feature macro: LCD_READ_EN
//   defined   : rw=1 transfers drive lcd_dout/lcd_doe. rs=0 returns {busy,ac}.
//               rs=1 returns the buffer byte at ac and steps ac.
//   undefined : rw=1 transfers are ignored and lcd_dout/lcd_doe are tied to 0.
//
// Parameters
//   SYNC_STAGES   synchroniser depth on all four bus inputs (>= 2)
//   CMD_CYCLES    busy duration after ordinary commands and data writes
//   CLEAR_CYCLES  busy duration after clear display / return home
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   lcd_rs, lcd_rw        register select, read/write select
//   lcd_en                enable strobe; a transfer is taken on its falling edge
//   lcd_data[7:0]         bus data from the driver
//   lcd_dout[7:0]         read data back to the driver
//   lcd_doe               read data output enable
//   char_addr[4:0]        buffer read index (0-15 line 1, 16-31 line 2)
//   char_data[7:0]        registered character at char_addr (1-cycle latency)
//   ac[6:0]               address counter
//   disp_on, cursor_on,
//   blink_on              D, C and B bits of display control
//   busy                  emulated busy flag
//   cmd_strobe            1-cycle pulse per accepted write transfer
//   proto_err             sticky: write while busy, or function set with DL=0
// ---------------------------------------------------------------------------
module lcd_bus_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int CMD_CYCLES   = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_dout,
    output logic       lcd_doe,
    input  logic [4:0] char_addr,
    output logic [7:0] char_data,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       proto_err
);

    localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE,
        OP_SET_DDRAM,
        OP_IGNORE,
        OP_FUNC,
        OP_DISP,
        OP_ENTRY,
        OP_HOME,
        OP_CLEAR,
        OP_DATA,
        OP_READ
    } op_t;

    // Next address-counter value under the two-line DDRAM map. Values outside
    // the map (reachable only through set-DDRAM) simply wrap modulo 128.
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h40)      return 7'h27;
            else if (a == 7'h00) return 7'h67;
            else                 return a - 7'd1;
        end
    endfunction

    // Returns {hit, buffer index}; hit is set for DDRAM 0x00-0x0F and 0x40-0x4F.
    function automatic logic [5:0] map_ac(input logic [6:0] a);
        if (a[6:4] == 3'b000)      return {1'b1, 1'b0, a[3:0]};
        else if (a[6:4] == 3'b100) return {1'b1, 1'b1, a[3:0]};
        else                       return 6'b0;
    endfunction

    logic [SYNC_STAGES-1:0][10:0] sync_chain;
    logic                         en_s;
    logic                         rs_s;
    logic                         rw_s;
    logic [7:0]                   data_s;
    logic                         en_prev;
    logic                         fall_evt;
    op_t                          op;
    logic                         write_acc;
    logic [5:0]                   ac_map;
    logic [CNT_W-1:0]             busy_cnt;
    logic                         inc_mode;
    logic [7:0]                   char_buf [32];

    // Synchroniser stage: all four bus inputs share one chain so rs/rw/data
    // stay aligned with the enable edge they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            en_prev    <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], {lcd_en, lcd_rs, lcd_rw, lcd_data}};
            en_prev    <= en_s;
        end
    end

    assign {en_s, rs_s, rw_s, data_s} = sync_chain[SYNC_STAGES-1];
    assign fall_evt = en_prev & ~en_s;
    assign ac_map   = map_ac(ac);
    assign busy     = (busy_cnt != '0);

    // Command decode: the highest set bit of the command byte selects the op.
    always_comb begin
        op = OP_NONE;
        if (fall_evt) begin
            if (rw_s) begin
                op = OP_READ;
            end else if (rs_s) begin
                op = OP_DATA;
            end else begin
                casez (data_s)
                    8'b1???????: op = OP_SET_DDRAM;
                    8'b01??????: op = OP_IGNORE;
                    8'b001?????: op = OP_FUNC;
                    8'b0001????: op = OP_IGNORE;
                    8'b00001???: op = OP_DISP;
                    8'b000001??: op = OP_ENTRY;
                    8'b0000001?: op = OP_HOME;
                    8'b00000001: op = OP_CLEAR;
                    default:     op = OP_NONE;
                endcase
            end
        end
    end

    // The all-zero command is a true no-op: no strobe and no busy reload.
    assign write_acc = (op != OP_NONE) && (op != OP_READ);

    // Update stage: one clock after the synchronised enable falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
            ac         <= 7'h00;
            inc_mode   <= 1'b1;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            busy_cnt   <= '0;
            proto_err  <= 1'b0;
            cmd_strobe <= 1'b0;
            char_data  <= 8'h00;
        end else begin
            // Sampled before any buffer write in this cycle lands.
            char_data  <= char_buf[char_addr];
            cmd_strobe <= write_acc;

            if (write_acc) begin
                if (op == OP_HOME || op == OP_CLEAR) busy_cnt <= CNT_W'(CLEAR_CYCLES);
                else                                 busy_cnt <= CNT_W'(CMD_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - CNT_W'(1);
            end

            // The write is still carried out when it arrives while busy.
            if (write_acc && (busy || (op == OP_FUNC && !data_s[4])))
                proto_err <= 1'b1;

            case (op)
                OP_SET_DDRAM: ac <= data_s[6:0];
                OP_DISP: begin
                    disp_on   <= data_s[2];
                    cursor_on <= data_s[1];
                    blink_on  <= data_s[0];
                end
                OP_ENTRY: inc_mode <= data_s[1];
                OP_HOME:  ac <= 7'h00;
                OP_CLEAR: begin
                    for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
                    ac       <= 7'h00;
                    inc_mode <= 1'b1;
                end
                OP_DATA: begin
                    if (ac_map[5]) char_buf[ac_map[4:0]] <= data_s;
                    ac <= step_ac(ac, inc_mode);
                end
                OP_READ: begin
`ifdef LCD_READ_EN
                    if (rs_s) ac <= step_ac(ac, inc_mode);
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_READ_EN
    logic [7:0] rd_char;

    assign rd_char = ac_map[5] ? char_buf[ac_map[4:0]] : 8'h20;

    // Read stage: drive while the synchronised enable is high on a read,
    // release on the falling-edge event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_doe  <= 1'b0;
            lcd_dout <= 8'h00;
        end else if (fall_evt) begin
            lcd_doe <= 1'b0;
        end else if (en_s && rw_s) begin
            lcd_doe  <= 1'b1;
            lcd_dout <= rs_s ? rd_char : {busy, ac};
        end
    end
`else
    assign lcd_dout = 8'h00;
    assign lcd_doe  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_responder
//
// Directed and randomised bus transfers against a reference model that holds
// a full 128-byte DDRAM image, the address counter and the busy window as
// (load cycle, duration) arithmetic. Short busy durations keep runtime low.
// ---------------------------------------------------------------------------
module tb_lcd_bus_responder;

    localparam int SYNC = 2;
    localparam int CMDC = 20;
    localparam int CLRC = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;
    logic [7:0] lcd_dout;
    logic       lcd_doe;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, busy, cmd_strobe, proto_err;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    // Reference model state
    logic [7:0]  m_ddram [128];
    logic [6:0]  m_ac;
    bit          m_id, m_d, m_c, m_b, m_err;
    int unsigned m_upd, m_dur;

    lcd_bus_responder #(
        .SYNC_STAGES (SYNC),
        .CMD_CYCLES  (CMDC),
        .CLEAR_CYCLES(CLRC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data),
        .lcd_dout  (lcd_dout),
        .lcd_doe   (lcd_doe),
        .char_addr (char_addr),
        .char_data (char_data),
        .ac        (ac),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .busy      (busy),
        .cmd_strobe(cmd_strobe),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mapped(input logic [6:0] a);
        return (a <= 7'h0F) || (a >= 7'h40 && a <= 7'h4F);
    endfunction

    function automatic logic [6:0] m_next(input logic [6:0] a);
        int v;
        if (m_id) v = (a == 7'h27) ? 'h40 : (a == 7'h67) ? 0 : (int'(a) + 1) % 128;
        else      v = (a == 7'h40) ? 'h27 : (a == 7'h00) ? 'h67 : (int'(a) + 127) % 128;
        return 7'(v);
    endfunction

    function automatic bit m_busy_now();
        return (cyc - m_upd) < m_dur;
    endfunction

    function automatic logic [6:0] char_to_addr(input int k);
        return (k < 16) ? 7'(k) : 7'(k + 'h30);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_ddram[i] = 8'h20;
        m_ac = 0; m_id = 1; m_d = 0; m_c = 0; m_b = 0; m_err = 0;
        m_upd = cyc; m_dur = 0;
    endtask

    task automatic do_reset();
        reset = 1; lcd_rs = 0; lcd_rw = 0; lcd_en = 0; lcd_data = 0; char_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_char_data", char_data, 8'h00);
        chk("reset_strobe", cmd_strobe, 0);
        reset = 0;
        model_reset();
    endtask

    // Apply one write transfer to the model; the update edge count is cyc.
    task automatic model_write(input bit rs, input logic [7:0] d, output bit strobe);
        bit          was_busy;
        int unsigned dur;
        strobe = 1;
        if (!rs && d == 8'h00) begin
            strobe = 0;
            return;
        end
        was_busy = (cyc - m_upd) <= m_dur && m_dur != 0;
        dur = CMDC;
        if (rs) begin
            if (m_mapped(m_ac)) m_ddram[m_ac] = d;
            m_ac = m_next(m_ac);
        end else if (d[7]) m_ac = d[6:0];
        else if (d[6]) ;
        else if (d[5]) begin
            if (!d[4]) m_err = 1;
        end else if (d[4]) ;
        else if (d[3]) begin
            m_d = d[2]; m_c = d[1]; m_b = d[0];
        end else if (d[2]) m_id = d[1];
        else if (d[1]) begin
            m_ac = 0; dur = CLRC;
        end else begin
            for (int i = 0; i < 128; i++) m_ddram[i] = 8'h20;
            m_ac = 0; m_id = 1; dur = CLRC;
        end
        if (was_busy) m_err = 1;
        m_upd = cyc;
        m_dur = dur;
    endtask

    // Pulse lcd_en and return #1 after the edge on which the state updates.
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1;
        repeat (2) @(posedge clk);
        #1;
        lcd_en = 0;
        repeat (SYNC + 1) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input bit strobe);
        chk("cmd_strobe", cmd_strobe, strobe);
        chk("ac", ac, m_ac);
        chk("disp_on", disp_on, m_d);
        chk("cursor_on", cursor_on, m_c);
        chk("blink_on", blink_on, m_b);
        chk("proto_err", proto_err, m_err);
        chk("busy", busy, m_busy_now());
    endtask

    task automatic wait_idle();
        int rem;
        rem = int'(m_dur) - int'(cyc - m_upd);
        if (rem > 0) begin
            repeat (rem) @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit rs, input logic [7:0] d, input bit idle_first);
        bit strobe;
        if (idle_first) wait_idle();
        xfer(rs, 1'b0, d);
        model_write(rs, d, strobe);
        check_state(strobe);
    endtask

    task automatic read_char(input int k, output logic [7:0] v);
        char_addr = 5'(k);
        @(posedge clk);
        #1;
        v = char_data;
    endtask

    task automatic check_chars();
        logic [7:0] v;
        for (int k = 0; k < 32; k++) begin
            read_char(k, v);
            chk($sformatf("char%0d", k), v, m_ddram[char_to_addr(k)]);
        end
    endtask

    task automatic read_xfer(input bit rs, input logic [7:0] exp_dout);
        lcd_rs = rs; lcd_rw = 1; lcd_data = 8'hA5; lcd_en = 1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
`ifdef LCD_READ_EN
        chk("read_doe_high", lcd_doe, 1);
        chk("read_dout", lcd_dout, exp_dout);
`else
        chk("read_doe_off", lcd_doe, 0);
        chk("read_dout_off", lcd_dout, 8'h00);
`endif
        lcd_en = 0;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        chk("read_doe_low", lcd_doe, 0);
`ifdef LCD_READ_EN
        if (rs) m_ac = m_next(m_ac);
`endif
        check_state(1'b0);
        lcd_rw = 0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] msg [5];
        int         n;
        int         r;
        logic [7:0] d;
        bit         rs;

        // Reset state
        do_reset();
        check_state(1'b0);
        check_chars();
        chk("reset_dout", lcd_dout, 8'h00);
        chk("reset_doe", lcd_doe, 0);

        // Init sequence and "12:34"
        wr(0, 8'h38, 1); wr(0, 8'h0C, 1); wr(0, 8'h06, 1); wr(0, 8'h80, 1);
        msg[0] = "1"; msg[1] = "2"; msg[2] = ":"; msg[3] = "3"; msg[4] = "4";
        for (int i = 0; i < 5; i++) wr(1, msg[i], 1);
        read_char(0, v); chk("clock_c0", v, 8'h31);
        read_char(1, v); chk("clock_c1", v, 8'h32);
        read_char(2, v); chk("clock_c2", v, 8'h3A);
        read_char(3, v); chk("clock_c3", v, 8'h33);
        read_char(4, v); chk("clock_c4", v, 8'h34);
        chk("clock_ac", ac, 7'h05);
        chk("clock_disp", disp_on, 1);
        chk("clock_cursor", cursor_on, 0);

        // Line 2 and the 0x27 -> 0x40 wrap with an unmapped write
        wr(0, 8'hC0, 1); wr(1, 8'h41, 1);
        read_char(16, v); chk("line2_A", v, 8'h41);
        chk("line2_ac", ac, 7'h41);
        wr(0, 8'hA7, 1); wr(1, 8'h5A, 1);
        chk("wrap_ac", ac, 7'h40);
        check_chars();

        // Decrement mode and 0x00 -> 0x67 wrap, then clear with busy length
        wr(0, 8'h04, 1); wr(0, 8'h80, 1); wr(1, 8'h78, 1);
        read_char(0, v); chk("dec_char0", v, 8'h78);
        chk("dec_ac", ac, 7'h67);
        wr(0, 8'h01, 1);
        n = 0;
        for (int i = 0; i < CLRC + 20; i++) begin
            if (!busy) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("clear_busy_len", n, CLRC);
        chk("clear_ac", ac, 7'h00);
        check_chars();
        chk("no_err_yet", proto_err, 0);

        // Reads: status during clear busy, then data read
        wr(0, 8'h01, 1);
        read_xfer(0, 8'h80);
        wr(0, 8'h80, 1); wr(1, 8'h52, 1); wr(0, 8'h80, 1);
        wait_idle();
        read_xfer(1, 8'h52);

        // Write while busy
        wr(0, 8'h0C, 1);
        wr(1, 8'h51, 0);
        chk("busy_write_err", proto_err, 1);
        wr(1, 8'h37, 1);
        chk("err_sticky", proto_err, 1);
        check_chars();

        // Function set with DL=0
        do_reset();
        chk("err_cleared", proto_err, 0);
        wr(0, 8'h28, 1);
        chk("dl0_err", proto_err, 1);
        wr(0, 8'h00, 1);

        // Randomised traffic
        do_reset();
        for (int step = 0; step < 160; step++) begin
            r = $urandom_range(0, 99);
            rs = 0;
            if (r < 40)      begin rs = 1; d = 8'($urandom_range(32, 126)); end
            else if (r < 52) d = 8'h80 | 8'($urandom_range(0, 127));
            else if (r < 60) d = 8'h04 | 8'($urandom_range(0, 3));
            else if (r < 68) d = 8'h08 | 8'($urandom_range(0, 7));
            else if (r < 72) d = 8'h02 | 8'($urandom_range(0, 1));
            else if (r < 75) d = 8'h01;
            else if (r < 79) d = 8'h10 | 8'($urandom_range(0, 15));
            else if (r < 83) d = 8'h40 | 8'($urandom_range(0, 63));
            else if (r < 86) d = 8'h00;
            else if (r < 97) d = 8'h38;
            else             d = 8'h20 | 8'($urandom_range(0, 31));
            wr(rs, d, ($urandom_range(0, 9) < 7));
            if (step % 20 == 19) check_chars();
        end
        check_chars();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
